byte_word_packer: RTL



---
 rtl/byte_word_packer_pkg.sv | 18 +
 rtl/byte_word_packer_if.sv | 30 +++
 rtl/byte_word_packer_lane_decoder.sv | 23 ++
 rtl/byte_word_packer.sv | 129 ++++++++++++
 4 files changed

// File: rtl/byte_word_packer_pkg.sv
// Shared types and helpers for the byte-to-word packer.
package packer_pkg;

    localparam int DEF_BYTE_W     = 8;
    localparam int DEF_WORD_BYTES = 4;
    localparam int DEF_WORD_W     = DEF_BYTE_W * DEF_WORD_BYTES;

    typedef logic [DEF_BYTE_W-1:0]     byte_t;
    typedef logic [DEF_WORD_W-1:0]     word_t;
    typedef logic [DEF_WORD_BYTES-1:0] keep_t;

    // Lane that receives the k-th byte of a word for the given byte order.
    function automatic int lane_of(input int k, input logic big_endian,
                                   input int nBytes = DEF_WORD_BYTES);
        return big_endian ? (nBytes - 1 - k) : k;
    endfunction

endpackage

// File: rtl/byte_word_packer_if.sv
// Byte-in / word-out stream bundle; slave is the packer view, master the
// producer/consumer view around it.
interface byte_word_packer_if
    import packer_pkg::*;
#(
    parameter int BYTE_W     = DEF_BYTE_W,
    parameter int WORD_BYTES = DEF_WORD_BYTES
);

    logic [BYTE_W-1:0]            in_data;
    logic                         in_valid;
    logic                         in_last;
    logic                         in_ready;
    logic [BYTE_W*WORD_BYTES-1:0] out_data;
    logic [WORD_BYTES-1:0]        out_keep;
    logic                         out_last;
    logic                         out_valid;
    logic                         out_ready;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_keep, out_last, out_valid
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_keep, out_last, out_valid
    );

endinterface

// File: rtl/byte_word_packer_lane_decoder.sv
// Turns the byte position within a word and the byte order into a one-hot
// lane write enable.
module byte_lane_decoder
    import packer_pkg::*;
#(
    parameter int WORD_BYTES = DEF_WORD_BYTES
) (
    input  logic [$clog2(WORD_BYTES)-1:0] fill_i,
    input  logic                          big_endian_i,
    output logic [WORD_BYTES-1:0]         lane_en_o
);

    // Raise exactly the lane that the current byte position maps to.
    always_comb begin
        lane_en_o = '0;
        for (int l = 0; l < WORD_BYTES; l++) begin
            if (l == lane_of(int'(fill_i), big_endian_i, WORD_BYTES)) begin
                lane_en_o[l] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/byte_word_packer.sv
// Packs a byte stream into words with per-word byte order, partial-word
// flush on in_last and full-rate streaming through a single output register.
module byte_word_packer
    import packer_pkg::*;
#(
    parameter int BYTE_W     = DEF_BYTE_W,
    parameter int WORD_BYTES = DEF_WORD_BYTES
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          big_endian,
    output logic [$clog2(WORD_BYTES)-1:0] fill_count,
    byte_word_packer_if.slave             bus
);

    localparam int                WORD_W   = BYTE_W * WORD_BYTES;
    localparam int                FILL_W   = $clog2(WORD_BYTES);
    localparam logic [FILL_W-1:0] LAST_POS = FILL_W'(WORD_BYTES - 1);

    logic [WORD_W-1:0]     accData_q, accData_d;
    logic [WORD_BYTES-1:0] accKeep_q, accKeep_d;
    logic                  order_q, order_d;
    logic [FILL_W-1:0]     fill_q, fill_d;
    logic [WORD_W-1:0]     outData_q, outData_d;
    logic [WORD_BYTES-1:0] outKeep_q, outKeep_d;
    logic                  outLast_q, outLast_d;
    logic                  outValid_q, outValid_d;

    logic                  inReady;
    logic                  accept;
    logic                  complete;
    logic                  laneOrder;
    logic [WORD_BYTES-1:0] laneEn;
    logic [WORD_W-1:0]     mergedData;
    logic [WORD_BYTES-1:0] mergedKeep;

    // The first byte of a word uses the live order input; later bytes use
    // the order latched when that first byte was taken.
    assign laneOrder = (fill_q == '0) ? big_endian : order_q;
    assign inReady   = !outValid_q || bus.out_ready;
    assign accept    = bus.in_valid && inReady;
    assign complete  = (fill_q == LAST_POS) || bus.in_last;

    byte_lane_decoder #(
        .WORD_BYTES (WORD_BYTES)
    ) u_lane_decoder (
        .fill_i       (fill_q),
        .big_endian_i (laneOrder),
        .lane_en_o    (laneEn)
    );

    // Accumulator contents with the incoming byte dropped into its lane.
    always_comb begin
        mergedData = accData_q;
        for (int l = 0; l < WORD_BYTES; l++) begin
            if (laneEn[l]) begin
                mergedData[l*BYTE_W +: BYTE_W] = bus.in_data;
            end
        end
        mergedKeep = accKeep_q | laneEn;
    end

    // Next state: drain the output word, grow the accumulator, or move a
    // completed word into the output register (reloading on the drain edge).
    always_comb begin
        accData_d  = accData_q;
        accKeep_d  = accKeep_q;
        order_d    = order_q;
        fill_d     = fill_q;
        outData_d  = outData_q;
        outKeep_d  = outKeep_q;
        outLast_d  = outLast_q;
        outValid_d = outValid_q;

        if (outValid_q && bus.out_ready) begin
            outValid_d = 1'b0;
        end

        if (accept) begin
            if (fill_q == '0) begin
                order_d = big_endian;
            end
            if (complete) begin
                outData_d  = mergedData;
                outKeep_d  = mergedKeep;
                outLast_d  = bus.in_last;
                outValid_d = 1'b1;
                accData_d  = '0;
                accKeep_d  = '0;
                fill_d     = '0;
            end else begin
                accData_d = mergedData;
                accKeep_d = mergedKeep;
                fill_d    = fill_q + 1'b1;
            end
        end
    end

    // State registers; reset drops any partial or pending word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            accData_q  <= '0;
            accKeep_q  <= '0;
            order_q    <= 1'b0;
            fill_q     <= '0;
            outData_q  <= '0;
            outKeep_q  <= '0;
            outLast_q  <= 1'b0;
            outValid_q <= 1'b0;
        end else begin
            accData_q  <= accData_d;
            accKeep_q  <= accKeep_d;
            order_q    <= order_d;
            fill_q     <= fill_d;
            outData_q  <= outData_d;
            outKeep_q  <= outKeep_d;
            outLast_q  <= outLast_d;
            outValid_q <= outValid_d;
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.out_data  = outData_q;
    assign bus.out_keep  = outKeep_q;
    assign bus.out_last  = outLast_q;
    assign bus.out_valid = outValid_q;
    assign fill_count    = fill_q;

endmodule
